// File: rtl/fp_pkg.sv
// Shared definitions for the IEEE-754 arithmetic blocks: flag bit positions,
// operand classes, and helpers derived from the exponent/fraction widths.
package fp_pkg;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } fp_class_e;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] word;
        word = ((64'd1 << exp_w) - 64'd1) << man_w;
        word = word | (64'd1 << (man_w - 1));
        return word;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Normalise a raw significand product, round to nearest even, and pack an
// IEEE word; out-of-range exponents saturate to infinity or flush to zero.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                       sign,
    input  logic signed [EXP_W+1:0]    exp_in,
    input  logic [2*MAN_W+1:0]         sig,
    output logic [EXP_W+MAN_W:0]       result,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       inexact
);
    localparam int ES_W  = EXP_W + 2;
    localparam int SIG_W = 2 * MAN_W + 2;
    localparam logic signed [ES_W-1:0] EXP_ONE = ES_W'(1);
    localparam logic signed [ES_W-1:0] EXP_MAX = ES_W'((1 << EXP_W) - 1);

    logic [SIG_W-2:0]        norm_sig;
    logic signed [ES_W-1:0]  exp_norm;
    logic signed [ES_W-1:0]  exp_rnd;
    logic [MAN_W-1:0]        frac;
    logic                    guard;
    logic                    sticky;
    logic                    round_up;
    logic [MAN_W:0]          frac_rnd;

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        overflow  = 1'b0;
        underflow = 1'b0;

        // Product of two [1,2) significands lies in [1,4); the leading one is
        // dropped here and becomes the implicit bit.
        if (sig[SIG_W-1]) begin
            norm_sig = sig[SIG_W-2:0];
            exp_norm = exp_in + EXP_ONE;
        end else begin
            norm_sig = {sig[SIG_W-3:0], 1'b0};
            exp_norm = exp_in;
        end

        frac     = norm_sig[SIG_W-2 -: MAN_W];
        guard    = norm_sig[MAN_W];
        sticky   = |norm_sig[MAN_W-1:0];
        round_up = guard && (sticky || frac[0]);
        frac_rnd = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
        exp_rnd  = frac_rnd[MAN_W] ? exp_norm + EXP_ONE : exp_norm;
        inexact  = guard || sticky;

        result = {sign, exp_rnd[EXP_W-1:0], frac_rnd[MAN_W-1:0]};

        if (exp_rnd >= EXP_MAX) begin
            overflow = 1'b1;
            inexact  = 1'b1;
            result   = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (exp_rnd < EXP_ONE) begin
            underflow = 1'b1;
            inexact   = 1'b1;
            result    = {sign, {(EXP_W + MAN_W){1'b0}}};
        end
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage back-pressurable IEEE-754 multiplier: S1 classify/exponent/product,
// S2 normalise/round, S3 special-case select into the output register.
module fp_mult_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic [3:0]             out_flags
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int ES_W  = EXP_W + 2;
    localparam int SIG_W = 2 * MAN_W + 2;
    localparam logic signed [ES_W-1:0] BIAS     = ES_W'(fp_bias(EXP_W));
    localparam logic [W-1:0]           QNAN     = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [EXP_W-1:0]       EXP_ONES = '1;

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e,
                                           input logic [MAN_W-1:0] f);
        if (e == '0) return ZERO;
        if (e == EXP_ONES) return (f == '0) ? INF : NAN;
        return NORMAL;
    endfunction

    logic                    en;
    logic [SIG_W-1:0]        sig_a;
    logic [SIG_W-1:0]        sig_b;
    logic signed [ES_W-1:0]  exp_sum;

    logic                    v1;
    logic                    sign1;
    fp_class_e               cls_a1, cls_b1;
    logic signed [ES_W-1:0]  exp1;
    logic [SIG_W-1:0]        sig1;

    logic [W-1:0]            rp_result;
    logic                    rp_ovf, rp_unf, rp_inx;

    logic                    v2;
    logic                    sign2;
    fp_class_e               cls_a2, cls_b2;
    logic [W-1:0]            res2;
    logic                    ovf2, unf2, inx2;

    logic [W-1:0]            sel_result;
    logic [3:0]              sel_flags;

    // A single stall enable freezes every stage together, so nothing is dropped.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    always_comb begin
        sig_a   = SIG_W'({1'b1, in_a[MAN_W-1:0]});
        sig_b   = SIG_W'({1'b1, in_b[MAN_W-1:0]});
        exp_sum = $signed(ES_W'(in_a[W-2 -: EXP_W]))
                + $signed(ES_W'(in_b[W-2 -: EXP_W])) - BIAS;
    end

    fp_round_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .sign      (sign1),
        .exp_in    (exp1),
        .sig       (sig1),
        .result    (rp_result),
        .overflow  (rp_ovf),
        .underflow (rp_unf),
        .inexact   (rp_inx)
    );

    always_comb begin
        sel_result                 = res2;
        sel_flags                  = '0;
        sel_flags[FLAG_OVERFLOW]   = ovf2;
        sel_flags[FLAG_UNDERFLOW]  = unf2;
        sel_flags[FLAG_INEXACT]    = inx2;

        if (cls_a2 == NAN || cls_b2 == NAN) begin
            sel_result = QNAN;
            sel_flags  = '0;
        end else if ((cls_a2 == ZERO && cls_b2 == INF) ||
                     (cls_a2 == INF && cls_b2 == ZERO)) begin
            sel_result              = QNAN;
            sel_flags               = '0;
            sel_flags[FLAG_INVALID] = 1'b1;
        end else if (cls_a2 == INF || cls_b2 == INF) begin
            sel_result = {sign2, EXP_ONES, {MAN_W{1'b0}}};
            sel_flags  = '0;
        end else if (cls_a2 == ZERO || cls_b2 == ZERO) begin
            sel_result = {sign2, {(W-1){1'b0}}};
            sel_flags  = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (en) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            if (v2) begin
                out_result <= sel_result;
                out_flags  <= sel_flags;
            end
        end
    end

    // NOTE: inner datapath registers carry no reset; the valid bits alone decide what is live.
    always_ff @(posedge clk) begin
        if (en && in_valid) begin
            sign1  <= in_a[W-1] ^ in_b[W-1];
            cls_a1 <= classify(in_a[W-2 -: EXP_W], in_a[MAN_W-1:0]);
            cls_b1 <= classify(in_b[W-2 -: EXP_W], in_b[MAN_W-1:0]);
            exp1   <= exp_sum;
            sig1   <= sig_a * sig_b;
        end
        if (en && v1) begin
            sign2  <= sign1;
            cls_a2 <= cls_a1;
            cls_b2 <= cls_b1;
            res2   <= rp_result;
            ovf2   <= rp_ovf;
            unf2   <= rp_unf;
            inx2   <= rp_inx;
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed and randomised checks of fp_mult_pipe in single and half precision,
// including back-pressure and mid-flight reset.
module tb_fp_mult_pipe;

    localparam int NRAND = 10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_result;
    logic [3:0]  out_flags;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0] h_in_a, h_in_b, h_out_result;
    logic [3:0]  h_out_flags;

    fp_mult_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (h_in_valid),
        .in_ready   (h_in_ready),
        .in_a       (h_in_a),
        .in_b       (h_in_b),
        .out_valid  (h_out_valid),
        .out_ready  (h_out_ready),
        .out_result (h_out_result),
        .out_flags  (h_out_flags)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;
    } vec_t;

    vec_t vecs[16];

    // Drive one pair into an idle pipeline and count cycles until its result appears.
    task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic [3:0] f, output int lat);
        @(negedge clk);
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            in_valid = 1'b0;
        end while (!out_valid && lat < 20);
        r = out_result;
        f = out_flags;
    endtask

    task automatic run_h(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic [3:0] f, output int lat);
        @(negedge clk);
        h_in_a = a;
        h_in_b = b;
        h_in_valid = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            h_in_valid = 1'b0;
        end while (!h_out_valid && lat < 20);
        r = h_out_result;
        f = h_out_flags;
    endtask

    // Half-precision reference: exact integer product, rounding by remainder comparison.
    function automatic logic [19:0] ref_h(input logic [15:0] a, input logic [15:0] b);
        int          ea, eb, e, sh;
        int unsigned prod, q, rem, half;
        logic        s, za, zb, ia, ib, na, nb, inx;
        s  = a[15] ^ b[15];
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 31) && (a[9:0] == 10'd0);
        ib = (eb == 31) && (b[9:0] == 10'd0);
        na = (ea == 31) && (a[9:0] != 10'd0);
        nb = (eb == 31) && (b[9:0] != 10'd0);
        if (na || nb) return {16'h7E00, 4'b0000};
        if ((za && ib) || (zb && ia)) return {16'h7E00, 4'b1000};
        if (ia || ib) return {s, 5'h1F, 10'h000, 4'b0000};
        if (za || zb) return {s, 15'h0000, 4'b0000};
        prod = (32'd1024 + 32'(a[9:0])) * (32'd1024 + 32'(b[9:0]));
        sh   = (prod >= 32'd2097152) ? 11 : 10;
        e    = ea + eb - 15 + (sh - 10);
        q    = prod >> sh;
        rem  = prod - (q << sh);
        half = 32'd1 << (sh - 1);
        inx  = (rem != 0);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == 32'd2048) begin
            q = 32'd1024;
            e++;
        end
        if (e >= 31) return {s, 5'h1F, 10'h000, 4'b0101};
        if (e <= 0) return {s, 15'h0000, 4'b0011};
        return {s, 5'(e), 10'(q), 3'b000, inx};
    endfunction

    logic [31:0] r;
    logic [3:0]  f;
    logic [15:0] hr;
    logic [15:0] ha, hb;
    logic [19:0] exp_h;
    logic [19:0] sb[$];
    logic [3:0]  pat = 4'b1001;
    int          lat, sent, recv;

    initial begin
        vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000};
        vecs[1]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001};
        vecs[2]  = '{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001};
        vecs[3]  = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001};
        vecs[4]  = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 4'b1000};
        vecs[5]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101};
        vecs[6]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011};
        vecs[7]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000};
        vecs[8]  = '{32'hFF812345, 32'h00000000, 32'h7FC00000, 4'b0000};
        vecs[9]  = '{32'h80000000, 32'h40400000, 32'h80000000, 4'b0000};
        vecs[10] = '{32'hC0400000, 32'h40400000, 32'hC1100000, 4'b0000};
        vecs[11] = '{32'h00400000, 32'h7F800000, 32'h7FC00000, 4'b1000};
        vecs[12] = '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 4'b0000};
        vecs[13] = '{32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000};
        vecs[14] = '{32'h3FC00000, 32'h3FAAAAAA, 32'h3FFFFFFF, 4'b0000};
        vecs[15] = '{32'h7F800000, 32'h7F800000, 32'h7F800000, 4'b0000};

        reset = 1'b1;
        in_valid = 1'b0;  in_a = '0;  in_b = '0;  out_ready = 1'b1;
        h_in_valid = 1'b0; h_in_a = '0; h_in_b = '0; h_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset out_result", out_result, 0);
        check("reset out_flags", out_flags, 0);
        check("reset h_out_valid", h_out_valid, 0);
        reset = 1'b0;
        @(negedge clk);
        check("post-reset in_ready", in_ready, 1);
        check("post-reset h_in_ready", h_in_ready, 1);

        foreach (vecs[i]) begin
            run_one(vecs[i].a, vecs[i].b, r, f, lat);
            check($sformatf("vec%0d result", i), r, vecs[i].res);
            check($sformatf("vec%0d flags", i), f, vecs[i].flags);
            check($sformatf("vec%0d latency", i), lat, 3);
        end

        // Back-pressure: 3.0 * 2^k streamed while out_ready follows 1,0,0,1.
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 100 && recv < 8; cyc++) begin
            @(negedge clk);
            out_ready = pat[cyc % 4];
            in_valid  = (sent < 8);
            in_a      = {1'b0, 8'(127 + sent), 23'd0};
            in_b      = 32'h40400000;
            #1;
            check("bp in_ready", in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                check($sformatf("bp result %0d", recv), out_result, {1'b0, 8'(128 + recv), 23'h400000});
                recv++;
            end
            if (in_valid && in_ready) sent++;
        end
        check("bp results received", recv, 8);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp drained", out_valid, 0);

        // Reset with three pairs in flight.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = 32'h3F800000;
            in_b = 32'h40000000 + 32'(k << 20);
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("midreset out_valid", out_valid, 0);
        check("midreset out_result", out_result, 0);
        check("midreset out_flags", out_flags, 0);
        reset = 1'b0;
        @(negedge clk);
        check("midreset in_ready", in_ready, 1);
        check("midreset no stale", out_valid, 0);
        run_one(32'h40000000, 32'h40000000, r, f, lat);
        check("post-reset result", r, 32'h40800000);
        check("post-reset flags", f, 4'b0000);
        check("post-reset latency", lat, 3);

        // Half precision directed.
        run_h(16'h3C00, 16'h4000, hr, f, lat);
        check("h 1x2 result", hr, 16'h4000);
        check("h 1x2 flags", f, 4'b0000);
        check("h 1x2 latency", lat, 3);
        run_h(16'h7BFF, 16'h4000, hr, f, lat);
        check("h ovf result", hr, 16'h7C00);
        check("h ovf flags", f, 4'b0101);

        // Half precision random stream against the reference model.
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < NRAND + 50 && recv < NRAND; cyc++) begin
            @(negedge clk);
            if (h_out_valid) begin
                exp_h = (sb.size() > 0) ? sb.pop_front() : 'x;
                check("h random", {h_out_result, h_out_flags}, exp_h);
                recv++;
            end
            if (sent < NRAND) begin
                ha = 16'($urandom);
                hb = 16'($urandom);
                h_in_a = ha;
                h_in_b = hb;
                h_in_valid = 1'b1;
                sb.push_back(ref_h(ha, hb));
                sent++;
            end else begin
                h_in_valid = 1'b0;
            end
        end
        check("h random count", recv, NRAND);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_mult_pipe.md
# fp_mult_pipe

Parametrised, fully pipelined IEEE-754 binary floating-point multiplier with valid/ready handshaking on both sides. It accepts one operand pair per cycle, rounds round-to-nearest-even, handles zero/infinity/NaN, and reports exception flags. It sits in the arithmetic datapath next to the single-precision multiplier and replaces its free-running stage counter with a back-pressurable pipeline.

## Interface
- EXP_W, 8: exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 23: stored fraction width; word width W = 1+EXP_W+MAN_W.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  reset; synchronous and active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair this cycle.
- in_a, in_b  in  W  operands, IEEE layout {sign, exp, frac}.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_result  out  W  product.
- out_flags  out  4  {invalid, overflow, underflow, inexact}.

## Operation
- Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Classification: exp==0 → zero (subnormal inputs flushed to zero, same sign); exp all-ones, frac==0 → inf; exp all-ones, frac!=0 → NaN.
- Sign = sign_a ^ sign_b for every non-NaN result.
- Special cases, in priority order: any NaN operand → canonical qNaN (sign 0, exp all-ones, frac MSB 1, rest 0), no flags; zero × inf → qNaN, invalid; inf × (inf or finite) → signed inf, no flags; zero × finite → signed zero, no flags.
- Normal path: significands {1,frac} multiplied to 2·(MAN_W+1) bits; exponent sum computed in EXP_W+2 signed bits as ea+eb-bias; product MSB set → shift right 1, exponent +1.
- Rounding: guard bit plus sticky (OR of all lower bits); increment when guard && (sticky || lsb). Mantissa carry-out after increment → exponent +1, fraction 0.
- Overflow: biased exponent ≥ 2^EXP_W-1 after rounding → signed inf, flags overflow+inexact.
- Underflow: biased exponent ≤ 0 after rounding → signed zero (flush-to-zero), flags underflow+inexact.
- inexact set whenever guard||sticky on the normal path.

## Timing
- Three register stages: S1 classify + exponent sum + significand product; S2 normalise + round; S3 special-case select, pack, output register.
- Latency: 3 cycles from input transfer to out_valid with out_ready held high; throughput 1 result/cycle.
- Global stall: en = !out_valid || out_ready; in_ready = en. When en=0 every stage and its valid bit hold; no result is dropped or duplicated.
- Per-stage valid bits travel with data; bubbles propagate as invalid stages.
- Simultaneous input and output transfer in the same cycle is legal and sustains full rate.
- out_result and out_flags hold stable while out_valid && !out_ready.
- Reset: all stage valids 0, out_valid=0, out_result=0, out_flags=0; in_ready=1 in the first cycle after reset is released. Reset mid-operation discards all in-flight pairs; no result of a pre-reset pair ever appears.

## Structure
- Shared package fp_pkg: flag bit indices (FLAG_INVALID=3, FLAG_OVERFLOW=2, FLAG_UNDERFLOW=1, FLAG_INEXACT=0), operand-class enum {ZERO, NORMAL, INF, NAN}, functions for bias and canonical-qNaN derived from EXP_W/MAN_W.
- One sub-module: fp_round_pack (combinational; takes sign, signed exponent, wide significand; returns packed word plus overflow/underflow/inexact). Used by S2/S3, reusable by a future adder.

## Test plan
- Default params, 0x3FC00000 × 0x40000000 (1.5×2.0) → 0x40400000, flags 0000, out_valid exactly 3 cycles after transfer.
- 0x3F800001 × 0x3FC00000 → tie, rounds to even 0x3FC00002, flags 0001; 0x00000000 × 0x7F800000 → 0x7FC00000, flags 1000.
- 0x7F000000 × 0x7F000000 → 0x7F800000, flags 0101; 0x00800000 × 0x3F000000 → 0x00000000, flags 0011; 0xFF800000 × 0x40000000 → 0xFF800000, flags 0000.
- Back-pressure: stream 8 pairs with out_ready toggling 1,0,0,1,… → all 8 results, in order, none lost or repeated; in_ready low exactly when out_valid && !out_ready.
- Reset asserted with 3 pairs in flight → next cycle out_valid=0, outputs 0; post-reset pair 0x40000000 × 0x40000000 → 0x40800000 as the first result.
- EXP_W=5, MAN_W=10 (binary16): 0x3C00 × 0x4000 → 0x4000; 0x7BFF × 0x4000 → 0x7C00, flags 0101; random compare against a reference model, 10k vectors.
